// File: rtl/spi2adc.sv
// SPI master for the MCP3002 10-bit dual-channel ADC.
// Each start pulse runs one 16-SCK frame and returns the result with a one-cycle valid strobe.
module spi2adc #(
  parameter int CLK_DIV = 25
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       channel,
  input  logic       ADC_SDO,
  output logic       ADC_SDI,
  output logic       ADC_CS,
  output logic       ADC_SCK,
  output logic [9:0] adc_data,
  output logic       data_valid,
  output logic       busy
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       half_q, half_d;
  logic             chan_q, chan_d;
  logic             sck_q, sck_d;
  logic             cs_q, cs_d;
  logic             sdi_q, sdi_d;
  logic [9:0]       shift_q, shift_d;
  logic [9:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  // half_q counts SCK half-periods: even = low half, odd = high half of period half_q/2+1
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    chan_d  = chan_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    sdi_d   = sdi_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          chan_d  = channel;
          div_d   = '0;
          half_d  = '0;
          sck_d   = 1'b0;
          cs_d    = 1'b0;
          sdi_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end

      SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          half_d = half_q + 1'b1;
          if (!half_q[0]) begin
            sck_d = 1'b1;
            // Periods 6..15 carry B9..B0; the null bit and trailing bit are dropped
            if (half_q >= 5'd10 && half_q <= 5'd28) begin
              shift_d = {shift_q[8:0], ADC_SDO};
            end
          end else begin
            sck_d = 1'b0;
            case (half_q)
              5'd1:    sdi_d = 1'b1;
              5'd3:    sdi_d = chan_q;
              5'd5:    sdi_d = 1'b1;
              default: sdi_d = 1'b0;
            endcase
            if (half_q == 5'd31) begin
              state_d = HOLD;
              cs_d    = 1'b1;
              sdi_d   = 1'b0;
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end
        end
      end

      HOLD: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      half_q  <= '0;
      chan_q  <= 1'b0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      sdi_q   <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      chan_q  <= chan_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      sdi_q   <= sdi_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign ADC_SCK    = sck_q;
  assign ADC_CS     = cs_q;
  assign ADC_SDI    = sdi_q;
  assign adc_data   = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi2adc.sv
// Bench for spi2adc: three instances (CLK_DIV 2, 3, 25), each driven by an MCP3002 model,
// with a scoreboard of expected conversion results.
module tb_spi2adc;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start_a [3];
  logic       chan_a  [3];
  logic [9:0] mval_a  [3];

  wire        sdo_a   [3];
  wire        sdi_a   [3];
  wire        cs_a    [3];
  wire        sck_a   [3];
  wire        valid_a [3];
  wire        busy_a  [3];
  wire [9:0]  data_a  [3];
  wire [31:0] rises_a [3];
  wire [3:0]  cmd_a   [3];

  logic [9:0] sb [$];
  logic [9:0] last_data [3];
  int checks = 0;
  int errors = 0;

  always #5 sysclk = ~sysclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    int         rise_n = 0;
    int         fall_n = 0;
    int         frame_rises = 0;
    int         k = 0;
    logic [3:0] cmd = '0;
    logic [3:0] frame_cmd = '0;
    logic       sdo = 1'b0;

    spi2adc #(.CLK_DIV(g == 0 ? 2 : (g == 1 ? 3 : 25))) u_dut (
      .sysclk    (sysclk),
      .rst_n     (rst_n),
      .start     (start_a[g]),
      .channel   (chan_a[g]),
      .ADC_SDO   (sdo_a[g]),
      .ADC_SDI   (sdi_a[g]),
      .ADC_CS    (cs_a[g]),
      .ADC_SCK   (sck_a[g]),
      .adc_data  (data_a[g]),
      .data_valid(valid_a[g]),
      .busy      (busy_a[g])
    );

    // MCP3002: DIN latched on SCK rise, DOUT driven on SCK fall; B9 appears in period 6
    always @(posedge sck_a[g] or negedge sck_a[g] or posedge cs_a[g]) begin
      if (cs_a[g]) begin
        if (rise_n != 0) begin
          frame_rises = rise_n;
          frame_cmd   = cmd;
        end
        rise_n = 0;
        fall_n = 0;
        cmd    = '0;
        sdo    = 1'b0;
      end else if (sck_a[g]) begin
        rise_n++;
        if (rise_n <= 4) cmd = {cmd[2:0], sdi_a[g]};
      end else begin
        fall_n++;
        k   = fall_n + 1;
        sdo = (k >= 6 && k <= 15) ? mval_a[g][4'(15 - k)] : 1'b0;
      end
    end

    assign sdo_a[g]   = sdo;
    assign rises_a[g] = frame_rises;
    assign cmd_a[g]   = frame_cmd;
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 3 : 25);
  endfunction

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting in the current cycle T; returns in the cycle busy falls.
  task automatic applyStimulus(input int i, input logic ch, input logic [9:0] val,
                               input int restart_at);
    int   d = div_of(i);
    int   valid_at = -1, valid_cnt = 0, cs_hi_at = -1, busy_lo_at = -1;
    int   run = 0, hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;
    logic cur = 1'b0;
    logic [9:0] e;
    mval_a[i]  = val;
    chan_a[i]  = ch;
    start_a[i] = 1'b1;
    sb.push_back(val);
    tick();
    start_a[i] = 1'b0;
    checkOutput("busy_rise", busy_a[i], 1);
    checkOutput("cs_fall", cs_a[i], 0);
    checkOutput("data_hold", data_a[i], last_data[i]);
    chan_a[i] = ~ch;
    for (int n = 1; n <= 40 * d + 10; n++) begin
      if (valid_a[i]) begin
        valid_cnt++;
        valid_at = n;
        checkOutput("sb_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("adc_data", data_a[i], e);
          last_data[i] = e;
        end
      end
      if (cs_a[i] && cs_hi_at < 0) cs_hi_at = n;
      if (n <= 32 * d + 1) begin
        if (sck_a[i] == cur) run++;
        else begin
          if (cur) begin
            hi_min = (run < hi_min) ? run : hi_min;
            hi_max = (run > hi_max) ? run : hi_max;
          end else begin
            lo_min = (run < lo_min) ? run : lo_min;
            lo_max = (run > lo_max) ? run : lo_max;
          end
          cur = sck_a[i];
          run = 1;
        end
      end
      if (!busy_a[i]) busy_lo_at = n;
      start_a[i] = (n == restart_at);
      if (busy_lo_at >= 0) break;
      tick();
    end
    start_a[i] = 1'b0;
    checkOutput("valid_latency", valid_at, 32 * d + 1);
    checkOutput("valid_count", valid_cnt, 1);
    checkOutput("cs_rise", cs_hi_at, 32 * d + 1);
    checkOutput("busy_fall", busy_lo_at, 33 * d + 1);
    checkOutput("sck_rises", rises_a[i], 16);
    checkOutput("cmd_bits", cmd_a[i], {1'b1, 1'b1, ch, 1'b1});
    checkOutput("sck_high_min", hi_min, d);
    checkOutput("sck_high_max", hi_max, d);
    checkOutput("sck_low_min", lo_min, d);
    checkOutput("sck_low_max", lo_max, d);
  endtask

  initial begin
    int vcount, bcount;
    for (int i = 0; i < 3; i++) begin
      start_a[i]   = 1'b0;
      chan_a[i]    = 1'b0;
      mval_a[i]    = '0;
      last_data[i] = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst_cs", cs_a[i], 1);
      checkOutput("rst_sck", sck_a[i], 0);
      checkOutput("rst_sdi", sdi_a[i], 0);
      checkOutput("rst_data", data_a[i], 0);
      checkOutput("rst_valid", valid_a[i], 0);
      checkOutput("rst_busy", busy_a[i], 0);
    end
    rst_n = 1'b1;
    tick();

    $display("[TB] CH0 read with ignored start at T+20");
    applyStimulus(0, 1'b0, 10'h2A5, 20);
    $display("[TB] CH1 read started in first idle cycle");
    applyStimulus(0, 1'b1, 10'h3FF, 0);
    tick();
    applyStimulus(0, 1'b1, 10'h000, 0);
    repeat (3) tick();
    $display("[TB] CLK_DIV=3 frames");
    applyStimulus(1, 1'b0, 10'h1A5, 0);
    applyStimulus(1, 1'b1, 10'h05A, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 1'b0, 10'h155, 0);
    mval_a[0]  = 10'h2C3;
    chan_a[0]  = 1'b0;
    start_a[0] = 1'b1;
    tick();
    start_a[0] = 1'b0;
    repeat (29) tick();
    rst_n      = 1'b0;
    start_a[0] = 1'b1;
    tick();
    rst_n      = 1'b1;
    start_a[0] = 1'b0;
    last_data[0] = '0;
    checkOutput("abort_cs", cs_a[0], 1);
    checkOutput("abort_sck", sck_a[0], 0);
    checkOutput("abort_sdi", sdi_a[0], 0);
    checkOutput("abort_busy", busy_a[0], 0);
    checkOutput("abort_valid", valid_a[0], 0);
    checkOutput("abort_data", data_a[0], 0);
    vcount = 0;
    bcount = 0;
    for (int n = 0; n < 200; n++) begin
      if (valid_a[0]) vcount++;
      if (busy_a[0]) bcount++;
      tick();
    end
    checkOutput("abort_no_valid", vcount, 0);
    checkOutput("abort_idle", bcount, 0);

    $display("[TB] back-to-back frames at CLK_DIV=25");
    for (int f = 0; f < 8; f++) begin
      applyStimulus(2, f[0], (f == 7) ? 10'h3FF : 10'(f * 146), 0);
      repeat (5000 - (33 * 25 + 1)) tick();
    end
    checkOutput("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi2adc.md
Name: spi2adc

Overview:
- SPI master that reads the on-board MCP3002 10-bit dual-channel ADC. It is the capture-side counterpart of the spi2dac output path.
- On each `start` pulse (typically the clktick sample tick), it runs one 16-SCK conversion frame on the selected channel and returns the 10-bit result with a one-cycle valid strobe.
- Its output feeds the same 10-bit sample datapath that drives spi2dac and pwm, so an ADC→processing→DAC loop can be closed at the sample rate.

Parameters:
- CLK_DIV, 25, sysclk cycles per SCK half-period (SCK = sysclk/(2*CLK_DIV); 50 MHz → 1 MHz). Legal range ≥2.

Ports:
- sysclk  input  1  system clock (50 MHz); all logic on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on sysclk rising edge
- start  input  1  one-cycle request to begin a conversion frame
- channel  input  1  ADC channel select (0 = CH0, 1 = CH1), captured with start
- ADC_SDO  input  1  serial data from ADC (DOUT)
- ADC_SDI  output  1  serial command to ADC (DIN)
- ADC_CS  output  1  chip select, active low
- ADC_SCK  output  1  SPI clock, idle low
- adc_data  output  10  last completed conversion result, B9 = MSB
- data_valid  output  1  one-cycle strobe: adc_data updated this cycle
- busy  output  1  high while a frame or post-frame hold is in progress

Behaviour:
- Interface: one clock (sysclk); reset is synchronous and active-low (rst_n).
- Reset values (rst_n=0 at a clock edge, also mid-frame):
  - ADC_CS=1, ADC_SCK=0, ADC_SDI=0.
  - adc_data=0, data_valid=0, busy=0.
  - FSM=IDLE, all counters=0.
  - A reset mid-frame aborts the frame; no data_valid is produced.
- Reset has priority over start in the same cycle.
- FSM states: IDLE → SHIFT → HOLD → IDLE.
- IDLE:
  - Outputs at rest values.
  - On start=1 at cycle T: latch channel, go to SHIFT.
  - busy=1 from T+1.
- SHIFT: 16 SCK periods k=1..16, each 2*CLK_DIV cycles (D = CLK_DIV).
  - Period k low half: cycles T+1+(k-1)*2D … T+(k-1)*2D+D. SCK=0.
  - Period k high half: the next D cycles. SCK=1.
  - ADC_CS=0 for the whole state, starting at T+1.
  - ADC_SDI is updated at the first cycle of each low half, giving command bits:
    - k1 = 1 (start)
    - k2 = 1 (single-ended)
    - k3 = latched channel
    - k4 = 1 (MSBF)
    - k5..16 = 0
  - ADC_SDO is sampled on the sysclk edge at which SCK goes 0→1, i.e. the first cycle of each high half.
  - The samples at k=6..15 are shifted into an internal register, MSB first (k6→B9 … k15→B0).
  - The samples at k=1..5 and k=16 are ignored.
- Frame end at cycle T+1+32D:
  - SCK=0, ADC_CS=1, ADC_SDI=0.
  - adc_data loaded with the shift register; data_valid=1 for exactly this cycle.
  - Go to HOLD.
- Latency from start to data_valid = 1 + 32*CLK_DIV cycles (801 at the default).
- HOLD:
  - ADC_CS held high for D cycles (tCSH).
  - busy falls at T+1+33D; the FSM returns to IDLE that cycle.
- start while busy=1 is ignored; it is not queued.
- A start in the first IDLE cycle after busy falls is accepted.
- adc_data holds its value between frames. It changes only on the data_valid cycle.
- channel changes after T have no effect on the current frame.
- The SCK divider counter width is ceil(log2(CLK_DIV))+1 bits; it wraps cleanly at CLK_DIV-1.

Test Plan (CLK_DIV=2 unless stated; ADC behavioural model drives DOUT on SCK falling edges per the MCP3002 frame):
- Basic CH0 read: model value 10'h2A5, start with channel=0 at T.
  - ADC_SDI bits sampled on SCK rising edges 1..4 = 1,1,0,1.
  - data_valid at T+65 with adc_data=10'h2A5.
  - ADC_CS low T+1..T+64; busy falls at T+67.
- CH1 read: model 10'h3FF, channel=1 → command bits 1,1,1,1; adc_data=10'h3FF. Repeat with 10'h000 → adc_data=10'h000.
- Start while busy: second start at T+20 → still exactly 16 SCK rising edges and a single data_valid. Start at T+67 → new frame with CS low at T+68.
- Reset mid-frame: rst_n=0 at T+30 for 1 cycle → next cycle ADC_CS=1, SCK=0, busy=0, no data_valid. adc_data=0 (it was 10'h155 from a previous frame).
- Back-to-back frames: start pulsed every 5000 cycles at default CLK_DIV=25, model values ramp 0..1023 → every result matches and latency = 801 cycles each.
- Divider edge case CLK_DIV=2 vs 3: SCK high and low halves each exactly CLK_DIV cycles, and exactly 16 SCK pulses per frame.
